spm_loader: RTL

Byte-stream boot loader that drives the scratchpad test port of `cpu_five_pipeline_top`: while the core is held off (`cpu_en` = 0), it accepts write, read-back and go commands over a valid/ready byte channel. It assembles little-endian 32-bit words and writes them into SPM. It reads SPM words back and serialises them onto a response byte channel. On the go command it raises `cpu_en` to release the pipeline. It sits between a UART/host byte bridge and the top-level test SPM ports.

---
 rtl/spm_loader_if.sv | 26 ++
 rtl/spm_loader.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/spm_loader_if.sv
// Byte channels from the host bridge plus the scratchpad test port, bundled for the boot loader.
interface spm_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [29:0] test_spm_addr;
    logic        test_spm_as_;
    logic        test_spm_rw;
    logic [31:0] test_spm_wr_data;
    logic [31:0] test_spm_rd_data;

    modport slave (
        input  in_data, in_valid, out_ready, test_spm_rd_data,
        output in_ready, out_data, out_valid,
        output test_spm_addr, test_spm_as_, test_spm_rw, test_spm_wr_data
    );

    modport master (
        output in_data, in_valid, out_ready, test_spm_rd_data,
        input  in_ready, out_data, out_valid,
        input  test_spm_addr, test_spm_as_, test_spm_rw, test_spm_wr_data
    );
endinterface

// File: rtl/spm_loader.sv
// Boot loader: W/R/G byte commands load and read back SPM words, then release the core via cpu_en.
module spm_loader (
    input  logic          clk,
    input  logic          reset,
    spm_loader_if.slave   bus,
    output logic          cpu_en
);
    localparam logic       READ  = 1'b1;
    localparam logic       WRITE = 1'b0;
    localparam logic [7:0] OP_W  = 8'h57;
    localparam logic [7:0] OP_R  = 8'h52;
    localparam logic [7:0] OP_G  = 8'h47;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_CNT, S_WDATA, S_WSTB, S_RSTB, S_RCAP, S_RSEND, S_RESP, S_RUN
    } state_t;

    state_t      state_q;
    logic [1:0]  idx_q;
    logic [31:0] sh_q;
    logic [29:0] addr_q;
    logic [15:0] cnt_q;
    logic [31:0] rdata_q;
    logic        is_wr_q;
    logic        is_go_q;
    logic [7:0]  out_data_q;
    logic        cpu_en_q;
    logic        as_q;
    logic        rw_q;
    logic [29:0] spm_addr_q;
    logic [31:0] wr_data_q;
    logic [31:0] word_d;

    // Bytes arrive LSB first, so each new byte shifts in from the top.
    assign word_d = {bus.in_data, sh_q[31:8]};

    assign bus.in_ready  = !reset && (state_q inside {S_IDLE, S_ADDR, S_CNT, S_WDATA});
    assign bus.out_valid = !reset && (state_q inside {S_RSEND, S_RESP});
    assign bus.out_data         = out_data_q;
    assign bus.test_spm_addr    = spm_addr_q;
    assign bus.test_spm_as_     = as_q;
    assign bus.test_spm_rw      = rw_q;
    assign bus.test_spm_wr_data = wr_data_q;
    assign cpu_en               = cpu_en_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            sh_q       <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            is_wr_q    <= 1'b0;
            is_go_q    <= 1'b0;
            out_data_q <= '0;
            cpu_en_q   <= 1'b0;
            as_q       <= 1'b1;
            rw_q       <= READ;
            spm_addr_q <= '0;
            wr_data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.in_valid) begin
                    idx_q <= '0;
                    case (bus.in_data)
                        OP_W: begin is_wr_q <= 1'b1; is_go_q <= 1'b0; state_q <= S_ADDR; end
                        OP_R: begin is_wr_q <= 1'b0; is_go_q <= 1'b0; state_q <= S_ADDR; end
                        OP_G: begin is_go_q <= 1'b1; out_data_q <= ACK; state_q <= S_RESP; end
                        default: begin is_go_q <= 1'b0; out_data_q <= NAK; state_q <= S_RESP; end
                    endcase
                end
                S_ADDR: if (bus.in_valid) begin
                    sh_q  <= word_d;
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        addr_q  <= word_d[29:0];
                        state_q <= S_CNT;
                    end
                end
                S_CNT: if (bus.in_valid) begin
                    if (idx_q == 2'd0) begin
                        cnt_q[7:0] <= bus.in_data;
                        idx_q      <= 2'd1;
                    end else begin
                        cnt_q[15:8] <= bus.in_data;
                        idx_q       <= 2'd0;
                        if ({bus.in_data, cnt_q[7:0]} == 16'd0) begin
                            out_data_q <= ACK;
                            state_q    <= S_RESP;
                        end else if (is_wr_q) begin
                            state_q <= S_WDATA;
                        end else begin
                            as_q       <= 1'b0;
                            rw_q       <= READ;
                            spm_addr_q <= addr_q;
                            state_q    <= S_RSTB;
                        end
                    end
                end
                S_WDATA: if (bus.in_valid) begin
                    sh_q  <= word_d;
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        wr_data_q  <= word_d;
                        spm_addr_q <= addr_q;
                        as_q       <= 1'b0;
                        rw_q       <= WRITE;
                        state_q    <= S_WSTB;
                    end
                end
                S_WSTB: begin
                    as_q   <= 1'b1;
                    rw_q   <= READ;
                    addr_q <= addr_q + 30'd1;
                    cnt_q  <= cnt_q - 16'd1;
                    if (cnt_q != 16'd1) begin
                        state_q <= S_WDATA;
                    end else begin
                        out_data_q <= ACK;
                        state_q    <= S_RESP;
                    end
                end
                S_RSTB: begin
                    as_q    <= 1'b1;
                    addr_q  <= addr_q + 30'd1;
                    cnt_q   <= cnt_q - 16'd1;
                    state_q <= S_RCAP;
                end
                S_RCAP: begin
                    rdata_q    <= bus.test_spm_rd_data;
                    out_data_q <= bus.test_spm_rd_data[7:0];
                    idx_q      <= '0;
                    state_q    <= S_RSEND;
                end
                S_RSEND: if (bus.out_ready) begin
                    idx_q <= idx_q + 2'd1;
                    if (idx_q != 2'd3) begin
                        out_data_q <= rdata_q[15:8];
                        rdata_q    <= {8'h00, rdata_q[31:8]};
                    end else if (cnt_q != 16'd0) begin
                        as_q       <= 1'b0;
                        rw_q       <= READ;
                        spm_addr_q <= addr_q;
                        state_q    <= S_RSTB;
                    end else begin
                        out_data_q <= ACK;
                        state_q    <= S_RESP;
                    end
                end
                S_RESP: if (bus.out_ready) begin
                    if (is_go_q) begin
                        cpu_en_q <= 1'b1;
                        state_q  <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: ;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
